// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one pipelined fp_add datapath among NREQ requesters.
//
// A combinational round-robin search picks one eligible requester per cycle.
// Its operands go into the issue register that drives the fp_add. A {valid, id}
// tag follows each issue through a LATENCY-deep shift register. When the tag
// reaches the end, fpa_result belongs to that requester and is returned.
// Per-requester outstanding counters limit each requester to MAX_OUT
// operations in flight.
//
// Ports
//   clock       : single clock, rising edge
//   reset_n     : asynchronous active-low reset
//   req_valid   : [NREQ] operation request per requester
//   req_ready   : [NREQ] one-hot grant; transfer when valid & ready
//   req_a/req_b : [NREQ*32] operands, requester i at bits [32i+31:32i]
//   fpa_dataa/b : registered operands to the fp_add instance
//   fpa_result  : fp_add result, valid LATENCY cycles after operands
//   resp_valid  : one-cycle pulse marking a returned result
//   resp_id     : owner of resp_data
//   resp_data   : returned sum (fpa_result)
//   busy        : any operation in flight

// Counter sanity checks, kept apart from the datapath.
module fp_add_arbiter_chk #(
   parameter int NREQ    = 4,
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input logic                 clock,
   input logic                 reset_n,
   input logic [NREQ*CW-1:0]   outstanding,
   input logic [NREQ-1:0]      inc,
   input logic [NREQ-1:0]      dec
);
   // Flag any counter overflow or underflow before it can happen.
   always @(posedge clock) begin
      if (reset_n) begin
         for (int i = 0; i < NREQ; i++) begin
            assert (!(inc[i] && !dec[i] && (outstanding[i*CW +: CW] >= CW'(MAX_OUT))));
            assert (!(dec[i] && !inc[i] && (outstanding[i*CW +: CW] == {CW{1'b0}})));
            assert (outstanding[i*CW +: CW] <= CW'(MAX_OUT));
         end
      end
   end
endmodule

module fp_add_arbiter #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 10,
   parameter int MAX_OUT = 4
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic [NREQ-1:0]                           req_valid,
   output logic [NREQ-1:0]                           req_ready,
   input  logic [NREQ*32-1:0]                        req_a,
   input  logic [NREQ*32-1:0]                        req_b,
   output logic [31:0]                               fpa_dataa,
   output logic [31:0]                               fpa_datab,
   input  logic [31:0]                               fpa_result,
   output logic                                      resp_valid,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
   output logic [31:0]                               resp_data,
   output logic                                      busy
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

   logic [IDW-1:0]     rr_ptr_r;
   logic [CW-1:0]      out_r [NREQ];
   logic               iss_vld_r;
   logic [IDW-1:0]     iss_id_r;
   logic [31:0]        dataa_r;
   logic [31:0]        datab_r;
   logic [LATENCY-1:0] tag_vld_r;
   logic [IDW-1:0]     tag_id_r [LATENCY];

   logic [NREQ-1:0]    rsp_hit_s;
   logic [NREQ-1:0]    elig_s;
   logic               grant_vld_s;
   logic [IDW-1:0]     grant_id_s;
   logic               accept_s;
   logic [31:0]        opa_s;
   logic [31:0]        opb_s;
   logic [NREQ*CW-1:0] out_flat_s;

   // (base + offset) mod NREQ, for offsets in 0..NREQ.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NREQ) begin
         return IDW'(sum - NREQ);
      end else begin
         return IDW'(sum);
      end
   endfunction

   // Eligibility. A response returning to i this cycle frees a slot at once,
   // so a requester at MAX_OUT can be accepted in the same cycle.
   always_comb begin
      rsp_hit_s = '0;
      elig_s    = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_hit_s[i] = tag_vld_r[LATENCY-1] && (tag_id_r[LATENCY-1] == IDW'(i));
         elig_s[i]    = req_valid[i] && ((out_r[i] < MAX_OUT_C) || rsp_hit_s[i]);
      end
   end

   // Round-robin search upward from rr_ptr with wrap-around; the first hit wins.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         grant_id_s  = (!grant_vld_s && elig_s[rr_index(rr_ptr_r, k)]) ? rr_index(rr_ptr_r, k) : grant_id_s;
         grant_vld_s = grant_vld_s | elig_s[rr_index(rr_ptr_r, k)];
      end
   end

   // One-hot ready. It is forced low while reset is held.
   always_comb begin
      req_ready = '0;
      if (grant_vld_s && reset_n) begin
         req_ready[grant_id_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   assign accept_s = grant_vld_s && reset_n;

   // Operand mux for the granted requester.
   always_comb begin
      opa_s = 32'h0000_0000;
      opb_s = 32'h0000_0000;
      for (int i = 0; i < NREQ; i++) begin
         opa_s = opa_s | ((grant_id_s == IDW'(i)) ? req_a[i*32 +: 32] : 32'h0000_0000);
         opb_s = opb_s | ((grant_id_s == IDW'(i)) ? req_b[i*32 +: 32] : 32'h0000_0000);
      end
   end

   // Issue stage: operands plus tag on accept; a zero bubble otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_r  <= '0;
         iss_vld_r <= 1'b0;
         iss_id_r  <= '0;
         dataa_r   <= 32'h0000_0000;
         datab_r   <= 32'h0000_0000;
      end else if (accept_s) begin
         rr_ptr_r  <= rr_index(grant_id_s, 1);
         iss_vld_r <= 1'b1;
         iss_id_r  <= grant_id_s;
         dataa_r   <= opa_s;
         datab_r   <= opb_s;
      end else begin
         rr_ptr_r  <= rr_ptr_r;
         iss_vld_r <= 1'b0;
         iss_id_r  <= '0;
         dataa_r   <= 32'h0000_0000;
         datab_r   <= 32'h0000_0000;
      end
   end

   // Tag shift register. The last stage lines up with fpa_result for the same
   // operand pair, so it drives the response directly.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld_r <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            tag_id_r[s] <= '0;
         end
      end else begin
         tag_vld_r[0] <= iss_vld_r;
         tag_id_r[0]  <= iss_id_r;
         for (int s = 1; s < LATENCY; s++) begin
            tag_vld_r[s] <= tag_vld_r[s-1];
            tag_id_r[s]  <= tag_id_r[s-1];
         end
      end
   end

   // Outstanding counters. Accept and response together cancel out.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREQ; i++) begin
            out_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            case ({req_ready[i], rsp_hit_s[i]})
               2'b10:   out_r[i] <= out_r[i] + CW'(1'b1);
               2'b01:   out_r[i] <= out_r[i] - CW'(1'b1);
               default: out_r[i] <= out_r[i];
            endcase
         end
      end
   end

   // Flatten the counters for the checker.
   always_comb begin
      out_flat_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         out_flat_s[i*CW +: CW] = out_r[i];
      end
   end

   fp_add_arbiter_chk #(
      .NREQ    (NREQ),
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
   ) u_chk (
      .clock       (clock),
      .reset_n     (reset_n),
      .outstanding (out_flat_s),
      .inc         (req_ready),
      .dec         (rsp_hit_s)
   );

   assign fpa_dataa  = dataa_r;
   assign fpa_datab  = datab_r;
   assign resp_valid = tag_vld_r[LATENCY-1];
   assign resp_id    = tag_id_r[LATENCY-1];
   assign resp_data  = fpa_result;
   assign busy       = iss_vld_r | (|tag_vld_r);
endmodule
